e203_icb_splt: RTL and testbench

- One-to-N ICB splitter that sits directly downstream of the ICB arbiter. It takes the single arbitrated ICB master and routes each command to one of SPLT_NUM slave ports, using a one-hot port indication decoded upstream from the address.
- It records the target port of every accepted command in an outstanding-ID FIFO. Responses are returned to the master strictly in command order.
- Used in front of peripheral/memory slaves (ITCM, DTCM, CLINT, PLIC, system bus).

---
 rtl/e203_icb_splt.sv | 176 +++++++++++++++++
 tb/tb_e203_icb_splt.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_icb_splt.sv
// One-to-N ICB splitter. Routes each master command to the slave port picked
// by a one-hot indication and returns responses to the master in command order.
// The target port of every accepted command waits in a small outstanding-ID FIFO.
module e203_icb_splt #(
    parameter int AW               = 32,
    parameter int DW               = 32,
    parameter int USR_W            = 1,
    parameter int SPLT_NUM         = 4,
    parameter int SPLT_PTR_W       = 2,
    parameter int FIFO_OUTS_NUM    = 2,
    parameter int ALLOW_DIFF       = 0,
    parameter int ALLOW_0CYCLE_RSP = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SPLT_NUM-1:0]       i_icb_splt_indic,
    input  logic                      i_icb_cmd_valid,
    output logic                      i_icb_cmd_ready,
    input  logic                      i_icb_cmd_read,
    input  logic [AW-1:0]             i_icb_cmd_addr,
    input  logic [DW-1:0]             i_icb_cmd_wdata,
    input  logic [DW/8-1:0]           i_icb_cmd_wmask,
    input  logic [1:0]                i_icb_cmd_size,
    input  logic [USR_W-1:0]          i_icb_cmd_usr,
    output logic                      i_icb_rsp_valid,
    input  logic                      i_icb_rsp_ready,
    output logic                      i_icb_rsp_err,
    output logic [DW-1:0]             i_icb_rsp_rdata,
    output logic [USR_W-1:0]          i_icb_rsp_usr,
    output logic [SPLT_NUM-1:0]       o_bus_icb_cmd_valid,
    input  logic [SPLT_NUM-1:0]       o_bus_icb_cmd_ready,
    output logic [SPLT_NUM-1:0]       o_bus_icb_cmd_read,
    output logic [SPLT_NUM*AW-1:0]    o_bus_icb_cmd_addr,
    output logic [SPLT_NUM*DW-1:0]    o_bus_icb_cmd_wdata,
    output logic [SPLT_NUM*DW/8-1:0]  o_bus_icb_cmd_wmask,
    output logic [SPLT_NUM*2-1:0]     o_bus_icb_cmd_size,
    output logic [SPLT_NUM*USR_W-1:0] o_bus_icb_cmd_usr,
    input  logic [SPLT_NUM-1:0]       o_bus_icb_rsp_valid,
    output logic [SPLT_NUM-1:0]       o_bus_icb_rsp_ready,
    input  logic [SPLT_NUM-1:0]       o_bus_icb_rsp_err,
    input  logic [SPLT_NUM*DW-1:0]    o_bus_icb_rsp_rdata,
    input  logic [SPLT_NUM*USR_W-1:0] o_bus_icb_rsp_usr
);

    // Command payload is broadcast to every port; only the valid is steered.
    for (genvar gi = 0; gi < SPLT_NUM; gi++) begin : g_payload
        assign o_bus_icb_cmd_read[gi]                 = i_icb_cmd_read;
        assign o_bus_icb_cmd_addr[gi*AW +: AW]        = i_icb_cmd_addr;
        assign o_bus_icb_cmd_wdata[gi*DW +: DW]       = i_icb_cmd_wdata;
        assign o_bus_icb_cmd_wmask[gi*(DW/8) +: DW/8] = i_icb_cmd_wmask;
        assign o_bus_icb_cmd_size[gi*2 +: 2]          = i_icb_cmd_size;
        assign o_bus_icb_cmd_usr[gi*USR_W +: USR_W]   = i_icb_cmd_usr;
    end

    if (SPLT_NUM == 1) begin : g_pass
        // A single port needs no ordering state: straight wires.
        assign o_bus_icb_cmd_valid = i_icb_cmd_valid;
        assign i_icb_cmd_ready     = o_bus_icb_cmd_ready[0];
        assign i_icb_rsp_valid     = o_bus_icb_rsp_valid[0];
        assign o_bus_icb_rsp_ready = i_icb_rsp_ready;
        assign i_icb_rsp_err       = o_bus_icb_rsp_err[0];
        assign i_icb_rsp_rdata     = o_bus_icb_rsp_rdata;
        assign i_icb_rsp_usr       = o_bus_icb_rsp_usr;
    end else begin : g_splt
        localparam int FP_W  = (FIFO_OUTS_NUM > 1) ? $clog2(FIFO_OUTS_NUM) : 1;
        localparam int CNT_W = $clog2(FIFO_OUTS_NUM + 1);

        logic [SPLT_PTR_W-1:0] fifo_mem [FIFO_OUTS_NUM];
        logic [FP_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  full_q, full_d;
        logic [SPLT_PTR_W-1:0] last_id_q, last_id_d;
        logic [SPLT_PTR_W-1:0] splt_id, head_id, rsp_id;
        logic                  fifo_empty, stall, cmd_hsk, rsp_hsk, rsp_qual;
        logic                  push_en, pop_en;
        logic                  sel_valid, sel_err;
        logic [DW-1:0]         sel_rdata;
        logic [USR_W-1:0]      sel_usr;

        // Binary encode of the one-hot port indication.
        always_comb begin
            splt_id = '0;
            for (int k = 0; k < SPLT_NUM; k++) begin
                if (i_icb_splt_indic[k]) splt_id = splt_id | SPLT_PTR_W'(k);
            end
        end

        assign fifo_empty = (cnt_q == '0);
        assign head_id    = fifo_mem[rptr_q];
        // Without ALLOW_DIFF a port switch waits for all older responses,
        // which keeps ordering trivially safe across slaves.
        assign stall      = full_q | ((ALLOW_DIFF == 0) & ~fifo_empty & (splt_id != last_id_q));
        assign i_icb_cmd_ready = (|(i_icb_splt_indic & o_bus_icb_cmd_ready)) & ~stall;
        assign cmd_hsk    = i_icb_cmd_valid & i_icb_cmd_ready;

        // Oldest outstanding port answers; an empty FIFO may bypass to the
        // port being commanded this very cycle.
        assign rsp_id     = fifo_empty ? splt_id : head_id;
        assign rsp_qual   = ~fifo_empty | ((ALLOW_0CYCLE_RSP != 0) & cmd_hsk);

        for (genvar gi = 0; gi < SPLT_NUM; gi++) begin : g_port
            assign o_bus_icb_cmd_valid[gi] = i_icb_cmd_valid & i_icb_splt_indic[gi] & ~stall;
            assign o_bus_icb_rsp_ready[gi] = i_icb_rsp_ready & rsp_qual & (rsp_id == SPLT_PTR_W'(gi));
        end

        // Response mux from the selected port.
        always_comb begin
            sel_valid = 1'b0;
            sel_err   = 1'b0;
            sel_rdata = '0;
            sel_usr   = '0;
            for (int k = 0; k < SPLT_NUM; k++) begin
                if (rsp_id == SPLT_PTR_W'(k)) begin
                    sel_valid = o_bus_icb_rsp_valid[k];
                    sel_err   = o_bus_icb_rsp_err[k];
                    sel_rdata = o_bus_icb_rsp_rdata[k*DW +: DW];
                    sel_usr   = o_bus_icb_rsp_usr[k*USR_W +: USR_W];
                end
            end
        end

        assign i_icb_rsp_valid = sel_valid & rsp_qual;
        assign i_icb_rsp_err   = sel_err;
        assign i_icb_rsp_rdata = sel_rdata;
        assign i_icb_rsp_usr   = sel_usr;
        assign rsp_hsk         = i_icb_rsp_valid & i_icb_rsp_ready;

        // A zero-cycle transaction on an empty FIFO never touches the FIFO.
        assign push_en = cmd_hsk & ~(fifo_empty & rsp_hsk);
        assign pop_en  = rsp_hsk & ~fifo_empty;

        // Next-state for pointers, occupancy and the last pushed id.
        always_comb begin
            wptr_d    = wptr_q;
            rptr_d    = rptr_q;
            cnt_d     = cnt_q;
            last_id_d = last_id_q;
            if (push_en) begin
                wptr_d    = (wptr_q == FP_W'(FIFO_OUTS_NUM - 1)) ? '0 : wptr_q + 1'b1;
                last_id_d = splt_id;
            end
            if (pop_en) begin
                rptr_d = (rptr_q == FP_W'(FIFO_OUTS_NUM - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            full_d = (cnt_d == CNT_W'(FIFO_OUTS_NUM));
        end

        // FIFO control registers; reset discards every outstanding id.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q    <= '0;
                rptr_q    <= '0;
                cnt_q     <= '0;
                full_q    <= 1'b0;
                last_id_q <= '0;
            end else begin
                wptr_q    <= wptr_d;
                rptr_q    <= rptr_d;
                cnt_q     <= cnt_d;
                full_q    <= full_d;
                last_id_q <= last_id_d;
            end
        end

        // FIFO storage; contents are meaningless while the count says empty.
        always_ff @(posedge clk) begin
            if (push_en) fifo_mem[wptr_q] <= splt_id;
        end
    end

endmodule

// File: tb/tb_e203_icb_splt.sv
// Bench for e203_icb_splt: directed scenarios on an ALLOW_DIFF=0 instance (a_*)
// and an ALLOW_DIFF=1 instance (d_*) sharing stimulus, plus a randomized run
// checked against a queue-based reference model of both.
module tb_e203_icb_splt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   indic;
    logic         cmd_valid, cmd_read, rsp_ready;
    logic [31:0]  addr, wdata;
    logic [3:0]   wmask;
    logic [1:0]   size;
    logic [0:0]   usr;
    logic [3:0]   bus_cmd_ready, bus_rsp_valid, bus_rsp_err, bus_rsp_usr;
    logic [127:0] bus_rsp_rdata;

    logic         a_cmd_ready, a_rsp_valid, a_rsp_err;
    logic [31:0]  a_rsp_rdata;
    logic [0:0]   a_rsp_usr;
    logic [3:0]   a_bus_cmd_valid, a_bus_cmd_read, a_bus_cmd_usr, a_bus_rsp_ready;
    logic [127:0] a_bus_cmd_addr, a_bus_cmd_wdata;
    logic [15:0]  a_bus_cmd_wmask;
    logic [7:0]   a_bus_cmd_size;

    logic         d_cmd_ready, d_rsp_valid, d_rsp_err;
    logic [31:0]  d_rsp_rdata;
    logic [0:0]   d_rsp_usr;
    logic [3:0]   d_bus_cmd_valid, d_bus_cmd_read, d_bus_cmd_usr, d_bus_rsp_ready;
    logic [127:0] d_bus_cmd_addr, d_bus_cmd_wdata;
    logic [15:0]  d_bus_cmd_wmask;
    logic [7:0]   d_bus_cmd_size;

    int total = 0;
    int bad = 0;
    int illegal_cnt = 0;

    always #5 clk = ~clk;

    e203_icb_splt dut_a (
        .clk(clk), .rst_n(rst_n), .i_icb_splt_indic(indic),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(a_cmd_ready),
        .i_icb_cmd_read(cmd_read), .i_icb_cmd_addr(addr), .i_icb_cmd_wdata(wdata),
        .i_icb_cmd_wmask(wmask), .i_icb_cmd_size(size), .i_icb_cmd_usr(usr),
        .i_icb_rsp_valid(a_rsp_valid), .i_icb_rsp_ready(rsp_ready),
        .i_icb_rsp_err(a_rsp_err), .i_icb_rsp_rdata(a_rsp_rdata), .i_icb_rsp_usr(a_rsp_usr),
        .o_bus_icb_cmd_valid(a_bus_cmd_valid), .o_bus_icb_cmd_ready(bus_cmd_ready),
        .o_bus_icb_cmd_read(a_bus_cmd_read), .o_bus_icb_cmd_addr(a_bus_cmd_addr),
        .o_bus_icb_cmd_wdata(a_bus_cmd_wdata), .o_bus_icb_cmd_wmask(a_bus_cmd_wmask),
        .o_bus_icb_cmd_size(a_bus_cmd_size), .o_bus_icb_cmd_usr(a_bus_cmd_usr),
        .o_bus_icb_rsp_valid(bus_rsp_valid), .o_bus_icb_rsp_ready(a_bus_rsp_ready),
        .o_bus_icb_rsp_err(bus_rsp_err), .o_bus_icb_rsp_rdata(bus_rsp_rdata),
        .o_bus_icb_rsp_usr(bus_rsp_usr)
    );

    e203_icb_splt #(.ALLOW_DIFF(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .i_icb_splt_indic(indic),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(d_cmd_ready),
        .i_icb_cmd_read(cmd_read), .i_icb_cmd_addr(addr), .i_icb_cmd_wdata(wdata),
        .i_icb_cmd_wmask(wmask), .i_icb_cmd_size(size), .i_icb_cmd_usr(usr),
        .i_icb_rsp_valid(d_rsp_valid), .i_icb_rsp_ready(rsp_ready),
        .i_icb_rsp_err(d_rsp_err), .i_icb_rsp_rdata(d_rsp_rdata), .i_icb_rsp_usr(d_rsp_usr),
        .o_bus_icb_cmd_valid(d_bus_cmd_valid), .o_bus_icb_cmd_ready(bus_cmd_ready),
        .o_bus_icb_cmd_read(d_bus_cmd_read), .o_bus_icb_cmd_addr(d_bus_cmd_addr),
        .o_bus_icb_cmd_wdata(d_bus_cmd_wdata), .o_bus_icb_cmd_wmask(d_bus_cmd_wmask),
        .o_bus_icb_cmd_size(d_bus_cmd_size), .o_bus_icb_cmd_usr(d_bus_cmd_usr),
        .o_bus_icb_rsp_valid(bus_rsp_valid), .o_bus_icb_rsp_ready(d_bus_rsp_ready),
        .o_bus_icb_rsp_err(bus_rsp_err), .o_bus_icb_rsp_rdata(bus_rsp_rdata),
        .o_bus_icb_rsp_usr(bus_rsp_usr)
    );

    // Port indication must be one-hot whenever a command is offered.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && !$onehot(indic)) begin
            illegal_cnt++;
            $display("illegal indication %b while cmd_valid", indic);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        indic = 4'b0001; cmd_valid = 1'b0; cmd_read = 1'b0; rsp_ready = 1'b0;
        addr = '0; wdata = '0; wmask = '0; size = '0; usr = '0;
        bus_cmd_ready = '0; bus_rsp_valid = '0; bus_rsp_err = '0; bus_rsp_usr = '0;
        bus_rsp_rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model: q holds port ids of accepted, unanswered commands, oldest first.
    function automatic void model_eval(input int n, input int head, input int tail, input bit ad,
                                       output int sid, output logic cr, output logic [3:0] cv,
                                       output logic hsk, output logic rv, output logic [3:0] rr,
                                       output int rid);
        bit st;
        bit qual;
        sid = 0;
        for (int k = 0; k < 4; k++) if (indic[k]) sid = k;
        st   = (n == 2) || (!ad && n != 0 && sid != tail);
        cr   = bus_cmd_ready[sid] && !st;
        cv   = (cmd_valid && !st) ? indic : 4'b0000;
        hsk  = cmd_valid && cr;
        rid  = (n == 0) ? sid : head;
        qual = (n != 0) || hsk;
        rv   = qual && bus_rsp_valid[rid];
        rr   = (rsp_ready && qual) ? (4'b0001 << rid) : 4'b0000;
    endfunction

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        indic = 4'b0000; rsp_ready = 1'b1; bus_rsp_valid = 4'hF; bus_cmd_ready = 4'hF;
        #3;
        total++; if (a_bus_cmd_valid !== 4'b0000) begin bad++; $display("FAIL reset_cmd_valid got=%b exp=0000", a_bus_cmd_valid); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_bus_rsp_ready !== 4'b0000) begin bad++; $display("FAIL reset_rsp_ready got=%b exp=0000", a_bus_rsp_ready); end
        total++; if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_zero_indic_ready got=%b exp=0", a_cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        $display("test_reset done");
    endtask

    task automatic test_write_port2;
        logic [31:0] a_v, w_v;
        do_reset();
        a_v = $urandom; w_v = $urandom;
        addr = a_v; wdata = w_v; indic = 4'b0100; cmd_valid = 1'b1; cmd_read = 1'b0;
        bus_cmd_ready = 4'b0100; rsp_ready = 1'b1; bus_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        total++; if (a_bus_cmd_valid !== 4'b0100) begin bad++; $display("FAIL wr2_cmd_valid got=%b exp=0100", a_bus_cmd_valid); end
        total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL wr2_cmd_ready got=%b exp=1", a_cmd_ready); end
        total++; if (a_bus_cmd_addr !== {4{a_v}}) begin bad++; $display("FAIL wr2_addr_repl got=%h exp=%h", a_bus_cmd_addr, {4{a_v}}); end
        total++; if (a_bus_cmd_read !== 4'b0000) begin bad++; $display("FAIL wr2_read got=%b exp=0000", a_bus_cmd_read); end
        tick();
        cmd_valid = 1'b0;
        #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr2_wait_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_bus_rsp_ready !== 4'b0100) begin bad++; $display("FAIL wr2_wait_ready got=%b exp=0100", a_bus_rsp_ready); end
        tick();
        tick();
        bus_rsp_valid = 4'b0100; bus_rsp_rdata[64 +: 32] = 32'h0;
        #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL wr2_rsp_valid got=%b exp=1", a_rsp_valid); end
        total++; if (a_rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr2_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        tick();
        #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr2_drained_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_bus_rsp_ready !== 4'b0000) begin bad++; $display("FAIL wr2_drained_ready got=%b exp=0000", a_bus_rsp_ready); end
        bus_rsp_valid = '0;
        $display("test_write_port2 done");
    endtask

    task automatic test_no_diff;
        do_reset();
        indic = 4'b0001; cmd_valid = 1'b1; cmd_read = 1'b1; bus_cmd_ready = 4'hF; rsp_ready = 1'b1;
        tick();
        indic = 4'b0010;
        #1;
        total++; if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL nodiff_stall_ready got=%b exp=0", a_cmd_ready); end
        total++; if (a_bus_cmd_valid !== 4'b0000) begin bad++; $display("FAIL nodiff_stall_valid got=%b exp=0000", a_bus_cmd_valid); end
        tick();
        bus_rsp_valid = 4'b0001;
        #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL nodiff_p0_rsp got=%b exp=1", a_rsp_valid); end
        total++; if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL nodiff_same_cycle_ready got=%b exp=0", a_cmd_ready); end
        tick();
        bus_rsp_valid = 4'b0000;
        #1;
        total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL nodiff_next_ready got=%b exp=1", a_cmd_ready); end
        total++; if (a_bus_cmd_valid !== 4'b0010) begin bad++; $display("FAIL nodiff_next_valid got=%b exp=0010", a_bus_cmd_valid); end
        tick();
        cmd_valid = 1'b0;
        $display("test_no_diff done");
    endtask

    task automatic test_full;
        do_reset();
        indic = 4'b1000; cmd_valid = 1'b1; bus_cmd_ready = 4'b1000; rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL full_accept%0d got=%b exp=1", i, a_cmd_ready); end
            tick();
        end
        #1;
        total++; if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL full_third_stall got=%b exp=0", a_cmd_ready); end
        tick();
        bus_rsp_valid = 4'b1000;
        #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL full_first_rsp got=%b exp=1", a_rsp_valid); end
        total++; if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL full_pop_no_unblock got=%b exp=0", a_cmd_ready); end
        tick();
        bus_rsp_valid = 4'b0000;
        #1;
        total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL full_next_accept got=%b exp=1", a_cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        $display("test_full done");
    endtask

    task automatic test_zero_cycle;
        do_reset();
        indic = 4'b0010; cmd_valid = 1'b1; cmd_read = 1'b1; bus_cmd_ready = 4'b0010;
        bus_rsp_valid = 4'b0010; rsp_ready = 1'b1; bus_rsp_rdata[32 +: 32] = 32'hDEADBEEF;
        #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL zc_rsp_valid got=%b exp=1", a_rsp_valid); end
        total++; if (a_rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL zc_rdata got=%h exp=deadbeef", a_rsp_rdata); end
        total++; if (a_bus_rsp_ready !== 4'b0010) begin bad++; $display("FAIL zc_rsp_ready got=%b exp=0010", a_bus_rsp_ready); end
        tick();
        cmd_valid = 1'b0; indic = 4'b0001; bus_cmd_ready = 4'b0001;
        #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL zc_fifo_empty_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL zc_fifo_empty_nostall got=%b exp=1", a_cmd_ready); end
        bus_rsp_valid = '0;
        $display("test_zero_cycle done");
    endtask

    task automatic test_diff_order;
        do_reset();
        indic = 4'b0001; cmd_valid = 1'b1; cmd_read = 1'b1; bus_cmd_ready = 4'hF; rsp_ready = 1'b1;
        tick();
        indic = 4'b0010;
        #1;
        total++; if (d_cmd_ready !== 1'b1) begin bad++; $display("FAIL diff_second_ready got=%b exp=1", d_cmd_ready); end
        tick();
        cmd_valid = 1'b0; bus_rsp_valid = 4'b0010;
        bus_rsp_rdata[0 +: 32] = 32'hA0A0_0000; bus_rsp_rdata[32 +: 32] = 32'hB1B1_1111;
        #1;
        total++; if (d_rsp_valid !== 1'b0) begin bad++; $display("FAIL diff_p1_held_valid got=%b exp=0", d_rsp_valid); end
        total++; if (d_bus_rsp_ready !== 4'b0001) begin bad++; $display("FAIL diff_p1_held_ready got=%b exp=0001", d_bus_rsp_ready); end
        tick();
        bus_rsp_valid = 4'b0011;
        #1;
        total++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'hA0A0_0000) begin bad++; $display("FAIL diff_first_p0 got=%b/%h exp=1/a0a00000", d_rsp_valid, d_rsp_rdata); end
        tick();
        bus_rsp_valid = 4'b0010;
        #1;
        total++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'hB1B1_1111) begin bad++; $display("FAIL diff_then_p1 got=%b/%h exp=1/b1b11111", d_rsp_valid, d_rsp_rdata); end
        total++; if (d_bus_rsp_ready !== 4'b0010) begin bad++; $display("FAIL diff_p1_ready got=%b exp=0010", d_bus_rsp_ready); end
        tick();
        bus_rsp_valid = 4'b0000;
        #1;
        total++; if (d_bus_rsp_ready !== 4'b0000) begin bad++; $display("FAIL diff_drained_ready got=%b exp=0000", d_bus_rsp_ready); end
        $display("test_diff_order done");
    endtask

    task automatic test_async_reset;
        do_reset();
        indic = 4'b1000; cmd_valid = 1'b1; bus_cmd_ready = 4'b1000;
        tick();
        tick();
        cmd_valid = 1'b0; bus_rsp_valid = 4'b1000; rsp_ready = 1'b1;
        #1;
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b exp=1", a_rsp_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL areset_rsp_valid got=%b exp=0", a_rsp_valid); end
        total++; if (a_bus_rsp_ready !== 4'b0000) begin bad++; $display("FAIL areset_rsp_ready got=%b exp=0000", a_bus_rsp_ready); end
        total++; if (a_bus_cmd_valid !== 4'b0000) begin bad++; $display("FAIL areset_cmd_valid got=%b exp=0000", a_bus_cmd_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL areset_late_rsp_dropped got=%b exp=0", a_rsp_valid); end
        indic = 4'b0010; bus_cmd_ready = 4'b0010; cmd_valid = 1'b1; bus_rsp_valid = 4'b0000;
        #1;
        total++; if (a_cmd_ready !== 1'b1 || a_bus_cmd_valid !== 4'b0010) begin bad++; $display("FAIL areset_route got=%b/%b exp=1/0010", a_cmd_ready, a_bus_cmd_valid); end
        tick();
        cmd_valid = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_random;
        int qa[$];
        int qd[$];
        int n, hd, tl, sid, rid;
        logic ecr, ehsk, erv;
        logic [3:0] ecv, err_v;
        logic gcr, grv, gerr;
        logic [3:0] gcv, grr;
        logic [31:0] grd, erd;
        int cyc_bad;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            indic = 4'b0001 << $urandom_range(0, 3);
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_read = 1'($urandom);
            addr = $urandom; wdata = $urandom; wmask = 4'($urandom); size = 2'($urandom); usr = 1'($urandom);
            bus_cmd_ready = 4'($urandom);
            bus_rsp_valid = 4'($urandom);
            bus_rsp_err = 4'($urandom);
            bus_rsp_usr = 4'($urandom);
            bus_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            cyc_bad = 0;
            total++; if (a_bus_cmd_wdata !== {4{wdata}}) begin bad++; $display("FAIL rnd_wdata_repl cyc=%0d got=%h exp=%h", c, a_bus_cmd_wdata, {4{wdata}}); end
            for (int m = 0; m < 2; m++) begin
                if (m == 0) begin
                    n = qa.size(); hd = (n != 0) ? qa[0] : 0; tl = (n != 0) ? qa[n-1] : 0;
                    gcr = a_cmd_ready; gcv = a_bus_cmd_valid; grv = a_rsp_valid; grr = a_bus_rsp_ready;
                    grd = a_rsp_rdata; gerr = a_rsp_err;
                end else begin
                    n = qd.size(); hd = (n != 0) ? qd[0] : 0; tl = (n != 0) ? qd[n-1] : 0;
                    gcr = d_cmd_ready; gcv = d_bus_cmd_valid; grv = d_rsp_valid; grr = d_bus_rsp_ready;
                    grd = d_rsp_rdata; gerr = d_rsp_err;
                end
                model_eval(n, hd, tl, (m == 1), sid, ecr, ecv, ehsk, erv, err_v, rid);
                erd = bus_rsp_rdata[rid*32 +: 32];
                total++; if (gcr !== ecr) begin bad++; $display("FAIL rnd_cmd_ready inst=%0d cyc=%0d got=%b exp=%b", m, c, gcr, ecr); end
                total++; if (gcv !== ecv) begin bad++; $display("FAIL rnd_cmd_valid inst=%0d cyc=%0d got=%b exp=%b", m, c, gcv, ecv); end
                total++; if (grv !== erv) begin bad++; $display("FAIL rnd_rsp_valid inst=%0d cyc=%0d got=%b exp=%b", m, c, grv, erv); end
                total++; if (grr !== err_v) begin bad++; $display("FAIL rnd_rsp_ready inst=%0d cyc=%0d got=%b exp=%b", m, c, grr, err_v); end
                if (erv) begin
                    total++; if (grd !== erd || gerr !== bus_rsp_err[rid]) begin bad++; $display("FAIL rnd_rsp_data inst=%0d cyc=%0d got=%h/%b exp=%h/%b", m, c, grd, gerr, erd, bus_rsp_err[rid]); end
                end
                // Advance the model to reflect this cycle's handshakes.
                if (!(n == 0 && ehsk && erv && rsp_ready)) begin
                    if (erv && rsp_ready) begin
                        if (m == 0) void'(qa.pop_front()); else void'(qd.pop_front());
                    end
                    if (ehsk) begin
                        if (m == 0) qa.push_back(sid); else qd.push_back(sid);
                    end
                end
            end
            tick();
        end
        cmd_valid = 1'b0;
        total++; if (illegal_cnt !== 0) begin bad++; $display("FAIL illegal_indication got=%0d exp=0", illegal_cnt); end
        $display("test_random done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_port2();
        test_no_diff();
        test_full();
        test_zero_cycle();
        test_diff_order();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
